// File: rtl/icb_sram_responder_if.sv
// icb_sram_responder_if: nice_icb command/response channel; master drives cmd and rsp_ready, slave drives cmd_ready and rsp
interface icb_sram_responder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_size, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_size, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/icb_sram_responder.sv
// icb_sram_responder: ICB SRAM target with in-order response FIFO; ports nice_clk, nice_rst, nice_icb (slave), busy, plus wait_cycles when ICB_WAIT_STATE_EN is defined
module icb_sram_responder #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          DEPTH_WORDS    = 1024,
  parameter int          RSP_FIFO_DEPTH = 2
) (
  input  logic                nice_clk,
  input  logic                nice_rst,
`ifdef ICB_WAIT_STATE_EN
  input  logic [3:0]          wait_cycles,
`endif
  icb_sram_responder_if.slave nice_icb,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int PW = RSP_FIFO_DEPTH > 1 ? $clog2(RSP_FIFO_DEPTH) : 1;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [32:0]   fifo [RSP_FIFO_DEPTH];
  logic [32:0]   s1;
  logic          s1_valid;
  logic [CW-1:0] cnt, fcnt;
  logic [PW-1:0] wp, rp;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic          err, cmd_hs, rsp_hs, stall;
  always_comb begin
    off = nice_icb.cmd_addr - ADDR_BASE;
    idx = off[AW+1:2];
    err = nice_icb.cmd_size == 2'd3
       || (nice_icb.cmd_size == 2'd1 && nice_icb.cmd_addr[0])
       || (nice_icb.cmd_size == 2'd2 && nice_icb.cmd_addr[1:0] != 2'd0)
       || off >= 32'(DEPTH_WORDS * 4);
    be = nice_icb.cmd_size == 2'd0 ? 4'b0001 << nice_icb.cmd_addr[1:0]
       : nice_icb.cmd_size == 2'd1 ? (nice_icb.cmd_addr[1] ? 4'b1100 : 4'b0011)
       : 4'b1111;
    nice_icb.cmd_ready = !nice_rst && cnt < CW'(RSP_FIFO_DEPTH) && !stall;
    cmd_hs = nice_icb.cmd_valid && nice_icb.cmd_ready;
    nice_icb.rsp_valid = !nice_rst && fcnt != '0;
    rsp_hs = nice_icb.rsp_valid && nice_icb.rsp_ready;
    nice_icb.rsp_rdata = nice_icb.rsp_valid ? fifo[rp][31:0] : 32'h0;
    nice_icb.rsp_err = nice_icb.rsp_valid && fifo[rp][32];
    busy = !nice_rst && cnt != '0;
  end
`ifdef ICB_WAIT_STATE_EN
  logic [3:0] wait_cnt;
  assign stall = wait_cnt != 4'd0;
  always_ff @(posedge nice_clk) begin
    if (nice_rst) wait_cnt <= 4'd0;
    else if (cmd_hs) wait_cnt <= wait_cycles;
    else if (stall) wait_cnt <= wait_cnt - 4'd1;
  end
`else
  assign stall = 1'b0;
`endif
  always_ff @(posedge nice_clk) begin
    if (cmd_hs && !nice_icb.cmd_read && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= nice_icb.cmd_wdata[8*i +: 8];
  end
  always_ff @(posedge nice_clk) begin
    if (nice_rst) begin
      cnt      <= '0;
      fcnt     <= '0;
      wp       <= '0;
      rp       <= '0;
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      cnt      <= cnt + CW'(cmd_hs) - CW'(rsp_hs);
      fcnt     <= fcnt + CW'(s1_valid) - CW'(rsp_hs);
      s1_valid <= cmd_hs;
      s1       <= {err, nice_icb.cmd_read && !err ? mem[idx] : 32'h0};
      if (s1_valid) begin
        fifo[wp] <= s1;
        wp       <= wp == PW'(RSP_FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (rsp_hs) rp <= rp == PW'(RSP_FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_icb_sram_responder.sv
// tb_icb_sram_responder: directed self-checking bench for icb_sram_responder
module tb_icb_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef ICB_WAIT_STATE_EN
  logic [3:0] wait_cycles = 4'd0;
`endif
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int cmd_cyc[$];
  int rsp_cyc[$];
  logic [31:0] rsp_data[$];
  logic rsp_errq[$];
  icb_sram_responder_if bus();
  icb_sram_responder dut (
    .nice_clk(clk),
    .nice_rst(rst),
`ifdef ICB_WAIT_STATE_EN
    .wait_cycles(wait_cycles),
`endif
    .nice_icb(bus),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (!rst && bus.cmd_valid && bus.cmd_ready) cmd_cyc.push_back(cyc);
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      rsp_cyc.push_back(cyc);
      rsp_data.push_back(bus.rsp_rdata);
      rsp_errq.push_back(bus.rsp_err);
    end
  end
  task automatic clear_q();
    cmd_cyc.delete();
    rsp_cyc.delete();
    rsp_data.delete();
    rsp_errq.delete();
  endtask
  task automatic issue(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [1:0] sz);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_read = rd;
    bus.cmd_wdata = wd;
    bus.cmd_size = sz;
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
    if (!bus.cmd_ready) begin
      total++;
      $display("FAIL issue_timeout addr=%h cmd_ready got 0 want 1", a);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int n);
    for (int i = 0; i < 100 && rsp_data.size() < n; i++) @(posedge clk);
    if (rsp_data.size() < n) begin
      total++;
      $display("FAIL rsp_timeout got %0d responses want %0d", rsp_data.size(), n);
    end
    #1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); else passed++;
    total++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL post_reset_cmd_ready got %b want 1", bus.cmd_ready); else passed++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_word();
    clear_q();
    bus.rsp_ready = 1'b1;
    issue(32'h10, 1'b0, 32'hDEADBEEF, 2'd2);
    issue(32'h10, 1'b1, 32'h0, 2'd2);
    wait_rsp(2);
    total++; if (rsp_errq[0] !== 1'b0) $display("FAIL word_wr_err got %b want 0", rsp_errq[0]); else passed++;
    total++; if (rsp_data[0] !== 32'h0) $display("FAIL word_wr_rdata got %h want 0", rsp_data[0]); else passed++;
    total++; if (rsp_data[1] !== 32'hDEADBEEF) $display("FAIL word_rd_rdata got %h want deadbeef", rsp_data[1]); else passed++;
    total++; if (rsp_errq[1] !== 1'b0) $display("FAIL word_rd_err got %b want 0", rsp_errq[1]); else passed++;
    total++; if (rsp_cyc[1] - cmd_cyc[1] !== 2) $display("FAIL word_latency got %0d want 2", rsp_cyc[1] - cmd_cyc[1]); else passed++;
    total++; if (cmd_cyc[1] - cmd_cyc[0] !== 1) $display("FAIL word_throughput got %0d want 1", cmd_cyc[1] - cmd_cyc[0]); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL word_busy_idle got %b want 0", busy); else passed++;
  endtask
  task automatic test_lanes();
    clear_q();
    issue(32'h20, 1'b0, 32'h11223344, 2'd2);
    issue(32'h22, 1'b0, 32'h00AA0000, 2'd0);
    issue(32'h20, 1'b0, 32'h0000BBCC, 2'd1);
    issue(32'h20, 1'b1, 32'h0, 2'd2);
    wait_rsp(4);
    total++; if (rsp_errq[1] !== 1'b0) $display("FAIL lanes_byte_err got %b want 0", rsp_errq[1]); else passed++;
    total++; if (rsp_data[3] !== 32'h11AABBCC) $display("FAIL lanes_rdata got %h want 11aabbcc", rsp_data[3]); else passed++;
  endtask
  task automatic test_errors();
    clear_q();
    issue(32'h0, 1'b0, 32'hCAFEF00D, 2'd2);
    issue(32'h2, 1'b1, 32'h0, 2'd2);
    issue(32'h1, 1'b0, 32'hFFFFFFFF, 2'd1);
    issue(32'h0, 1'b0, 32'hFFFFFFFF, 2'd3);
    issue(32'h1000, 1'b0, 32'hFFFFFFFF, 2'd2);
    issue(32'hFFC, 1'b0, 32'h5A5A5A5A, 2'd2);
    issue(32'h0, 1'b1, 32'h0, 2'd2);
    issue(32'hFFC, 1'b1, 32'h0, 2'd2);
    wait_rsp(8);
    total++; if (rsp_errq[0] !== 1'b0) $display("FAIL err_setup_err got %b want 0", rsp_errq[0]); else passed++;
    for (int i = 1; i <= 4; i++) begin
      total++; if (rsp_errq[i] !== 1'b1) $display("FAIL err_flag_%0d got %b want 1", i, rsp_errq[i]); else passed++;
      total++; if (rsp_data[i] !== 32'h0) $display("FAIL err_rdata_%0d got %h want 0", i, rsp_data[i]); else passed++;
    end
    total++; if (rsp_errq[5] !== 1'b0) $display("FAIL err_last_word_err got %b want 0", rsp_errq[5]); else passed++;
    total++; if (rsp_data[6] !== 32'hCAFEF00D) $display("FAIL err_mem_intact got %h want cafef00d", rsp_data[6]); else passed++;
    total++; if (rsp_data[7] !== 32'h5A5A5A5A) $display("FAIL err_last_word got %h want 5a5a5a5a", rsp_data[7]); else passed++;
  endtask
  task automatic test_back_to_back();
    clear_q();
    bus.rsp_ready = 1'b0;
    issue(32'h10, 1'b1, 32'h0, 2'd2);
    issue(32'h20, 1'b1, 32'h0, 2'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h0;
    bus.cmd_read = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready got %b want 0", bus.cmd_ready); else passed++;
    total++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid got %b want 1", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_rdata !== 32'hDEADBEEF) $display("FAIL bp_head_rdata got %h want deadbeef", bus.rsp_rdata); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL bp_busy got %b want 1", busy); else passed++;
    @(posedge clk);
    #1;
    total++; if (cmd_cyc.size() !== 2) $display("FAIL bp_accepted got %0d want 2", cmd_cyc.size()); else passed++;
    bus.rsp_ready = 1'b1;
    issue(32'h0, 1'b1, 32'h0, 2'd2);
    wait_rsp(3);
    total++; if (cmd_cyc[2] - rsp_cyc[0] !== 1) $display("FAIL bp_third_accept got %0d want 1 cycle after first rsp", cmd_cyc[2] - rsp_cyc[0]); else passed++;
    total++; if (rsp_data[0] !== 32'hDEADBEEF) $display("FAIL bp_order0 got %h want deadbeef", rsp_data[0]); else passed++;
    total++; if (rsp_data[1] !== 32'h11AABBCC) $display("FAIL bp_order1 got %h want 11aabbcc", rsp_data[1]); else passed++;
    total++; if (rsp_data[2] !== 32'hCAFEF00D) $display("FAIL bp_order2 got %h want cafef00d", rsp_data[2]); else passed++;
  endtask
  task automatic test_reset_mid();
    clear_q();
    bus.rsp_ready = 1'b0;
    issue(32'h10, 1'b1, 32'h0, 2'd2);
    issue(32'h0, 1'b1, 32'h0, 2'd2);
    repeat (3) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) $display("FAIL rmid_pending got %b want 1", bus.rsp_valid); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) $display("FAIL rmid_cmd_ready got %b want 0", bus.cmd_ready); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h20;
    bus.cmd_read = 1'b1;
    bus.cmd_size = 2'd2;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmid_rsp_valid got %b want 0", bus.rsp_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rmid_first_accept got %b want 1", bus.cmd_ready); else passed++;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_rsp(1);
    repeat (5) @(posedge clk);
    total++; if (rsp_data.size() !== 1) $display("FAIL rmid_rsp_count got %0d want 1", rsp_data.size()); else passed++;
    total++; if (rsp_data[0] !== 32'h11AABBCC) $display("FAIL rmid_rdata got %h want 11aabbcc", rsp_data[0]); else passed++;
    total++; if (rsp_errq[0] !== 1'b0) $display("FAIL rmid_err got %b want 0", rsp_errq[0]); else passed++;
    #1;
  endtask
`ifdef ICB_WAIT_STATE_EN
  task automatic test_wait_state();
    clear_q();
    bus.rsp_ready = 1'b1;
    wait_cycles = 4'd3;
    issue(32'h10, 1'b1, 32'h0, 2'd2);
    issue(32'h20, 1'b1, 32'h0, 2'd2);
    issue(32'h0, 1'b1, 32'h0, 2'd2);
    wait_rsp(3);
    total++; if (cmd_cyc[1] - cmd_cyc[0] !== 4) $display("FAIL wait_gap0 got %0d want 4", cmd_cyc[1] - cmd_cyc[0]); else passed++;
    total++; if (cmd_cyc[2] - cmd_cyc[1] !== 4) $display("FAIL wait_gap1 got %0d want 4", cmd_cyc[2] - cmd_cyc[1]); else passed++;
    total++; if (rsp_data[2] !== 32'hCAFEF00D) $display("FAIL wait_rdata got %h want cafef00d", rsp_data[2]); else passed++;
    wait_cycles = 4'd0;
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = 32'h0;
    bus.cmd_read = 1'b0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_size = 2'd2;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef ICB_WAIT_STATE_EN
    test_wait_state();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
